// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/execute handshake and control bundle bus for decode_stage
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_alu_mode;
    logic [3:0]      out_mem_mode;
    logic            out_a_sel;
    logic            out_b_sel;
    logic [1:0]      out_wb_sel;
    logic            out_reg_we;
    logic            out_branch;
    logic            out_jump;
    logic            out_illegal;
    logic            br_eq;
    logic            br_lt;
    logic            br_ltu;
    logic            br_taken;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready, br_eq, br_lt, br_ltu,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_mode, out_mem_mode, out_a_sel, out_b_sel, out_wb_sel,
               out_reg_we, out_branch, out_jump, out_illegal, br_taken
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready, br_eq, br_lt, br_ltu,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_mode, out_mem_mode, out_a_sel, out_b_sel, out_wb_sel,
               out_reg_we, out_branch, out_jump, out_illegal, br_taken
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with load-use bubble, flush and branch resolve
// Optional DECODE_PERF_CNT_EN adds perf_issued/perf_stall counters.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]   perf_issued,
    output logic [31:0]   perf_stall
`endif
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] inst;
    logic [2:0]  f3;
    assign inst = bus.in_inst;
    assign f3   = inst[14:12];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [XLEN-1:0] d_imm;
    logic [3:0]      d_alu, d_mem;
    logic            d_a_sel, d_b_sel, d_we, d_branch, d_jump, d_illegal;
    logic [1:0]      d_wb;

    // Illegal encodings fall through with every field at its inert default.
    always_comb begin
        d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_imm = '0;
        d_alu = 4'b0000; d_mem = 4'b1111; d_a_sel = 1'b0; d_b_sel = 1'b0;
        d_wb = 2'b00; d_we = 1'b0; d_branch = 1'b0; d_jump = 1'b0; d_illegal = 1'b0;
        case (inst[6:0])
            OP_LUI: begin
                d_rd = inst[11:7]; d_imm = imm_u; d_b_sel = 1'b1; d_we = 1'b1;
            end
            OP_AUIPC: begin
                d_rd = inst[11:7]; d_imm = imm_u; d_a_sel = 1'b1; d_b_sel = 1'b1; d_we = 1'b1;
            end
            OP_JAL: begin
                d_rd = inst[11:7]; d_imm = imm_j; d_a_sel = 1'b1; d_b_sel = 1'b1;
                d_wb = 2'b10; d_we = 1'b1; d_jump = 1'b1;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    d_rd = inst[11:7]; d_rs1 = inst[19:15]; d_imm = imm_i; d_b_sel = 1'b1;
                    d_wb = 2'b10; d_we = 1'b1; d_jump = 1'b1;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    d_rs1 = inst[19:15]; d_rs2 = inst[24:20]; d_imm = imm_b;
                    d_alu = {f3, inst[30]}; d_branch = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
                    d_illegal = 1'b1;
                end else begin
                    d_rd = inst[11:7]; d_rs1 = inst[19:15]; d_imm = imm_i; d_b_sel = 1'b1;
                    d_wb = 2'b01; d_mem = {f3, 1'b0}; d_we = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3[2] || f3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    d_rs1 = inst[19:15]; d_rs2 = inst[24:20]; d_imm = imm_s;
                    d_b_sel = 1'b1; d_mem = {f3, 1'b1};
                end
            end
            OP_IMM: begin
                d_rd = inst[11:7]; d_rs1 = inst[19:15]; d_imm = imm_i; d_b_sel = 1'b1;
                d_alu = {f3, inst[30]}; d_we = 1'b1;
            end
            OP_REG: begin
                d_rd = inst[11:7]; d_rs1 = inst[19:15]; d_rs2 = inst[24:20];
                d_alu = {f3, inst[30]}; d_we = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_rd == 5'd0) d_we = 1'b0;
    end

    logic       ld_pend;
    logic [4:0] ld_rd;
    logic       held_load, hazard, fire_in, fire_out, cond;

    function automatic logic uses_reg(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
        return (r != 5'd0) && (a == r || b == r);
    endfunction

    // Unused source fields decode to x0, so they can never match a nonzero load rd.
    assign held_load = bus.out_valid && (bus.out_wb_sel == 2'b01);
    assign hazard    = bus.in_valid &&
                       ((held_load && uses_reg(bus.out_rd, d_rs1, d_rs2)) ||
                        (ld_pend && uses_reg(ld_rd, d_rs1, d_rs2)));
    assign bus.in_ready = !rst && !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
    assign fire_in   = bus.in_valid && bus.in_ready;
    assign fire_out  = bus.out_valid && bus.out_ready;

    always_comb begin
        cond = 1'b0;
        case (bus.out_alu_mode[3:1])
            3'b000:  cond = bus.br_eq;
            3'b001:  cond = !bus.br_eq;
            3'b100:  cond = bus.br_lt;
            3'b101:  cond = !bus.br_lt;
            3'b110:  cond = bus.br_ltu;
            3'b111:  cond = !bus.br_ltu;
            default: cond = 1'b0;
        endcase
    end
    assign bus.br_taken = bus.out_valid && ((bus.out_branch && cond) || bus.out_jump);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_rs1      <= '0;
            bus.out_rs2      <= '0;
            bus.out_rd       <= '0;
            bus.out_imm      <= '0;
            bus.out_alu_mode <= 4'b0000;
            bus.out_mem_mode <= 4'b1111;
            bus.out_a_sel    <= 1'b0;
            bus.out_b_sel    <= 1'b0;
            bus.out_wb_sel   <= 2'b00;
            bus.out_reg_we   <= 1'b0;
            bus.out_branch   <= 1'b0;
            bus.out_jump     <= 1'b0;
            bus.out_illegal  <= 1'b0;
            ld_pend          <= 1'b0;
            ld_rd            <= '0;
        end else begin
            ld_pend <= !bus.flush && fire_out && held_load;
            ld_rd   <= bus.out_rd;
            if (bus.flush) begin
                bus.out_valid <= 1'b0;
            end else if (fire_in) begin
                bus.out_valid    <= 1'b1;
                bus.out_pc       <= bus.in_pc;
                bus.out_rs1      <= d_rs1;
                bus.out_rs2      <= d_rs2;
                bus.out_rd       <= d_rd;
                bus.out_imm      <= d_imm;
                bus.out_alu_mode <= d_alu;
                bus.out_mem_mode <= d_mem;
                bus.out_a_sel    <= d_a_sel;
                bus.out_b_sel    <= d_b_sel;
                bus.out_wb_sel   <= d_wb;
                bus.out_reg_we   <= d_we;
                bus.out_branch   <= d_branch;
                bus.out_jump     <= d_jump;
                bus.out_illegal  <= d_illegal;
            end else if (fire_out) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (fire_out) perf_issued <= perf_issued + 32'd1;
            if (bus.in_valid && !bus.in_ready && !bus.flush) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
`endif
    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DECODE_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu, mem;
        logic        a_sel, b_sel;
        logic [1:0]  wb;
        logic        we, br, jmp, ill;
    } exp_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode written from the ISA field layouts with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        logic signed [31:0] s;
        logic [2:0] f3;
        logic writes;
        s = i; f3 = i[14:12]; writes = 1'b0;
        e = '0; e.mem = 4'hf;
        case (i[6:0])
            7'h37: begin e.rd = i[11:7]; e.imm = {i[31:12], 12'h0}; e.b_sel = 1; writes = 1; end
            7'h17: begin e.rd = i[11:7]; e.imm = {i[31:12], 12'h0}; e.a_sel = 1; e.b_sel = 1; writes = 1; end
            7'h6f: begin
                e.rd = i[11:7];
                e.imm = 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
                e.a_sel = 1; e.b_sel = 1; e.wb = 2; e.jmp = 1; writes = 1;
            end
            7'h67: if (f3 == 0) begin
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 32'(s >>> 20);
                e.b_sel = 1; e.wb = 2; e.jmp = 1; writes = 1;
            end else e.ill = 1;
            7'h63: if (f3 == 2 || f3 == 3) e.ill = 1; else begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.alu = {f3, i[30]}; e.br = 1;
                e.imm = 32'((s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 32'(s >>> 20);
                e.b_sel = 1; e.wb = 1; e.mem = {f3, 1'b0}; writes = 1;
            end else e.ill = 1;
            7'h23: if (f3 <= 2) begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = 32'((s >>> 25) << 5) | 32'(i[11:7]);
                e.b_sel = 1; e.mem = {f3, 1'b1};
            end else e.ill = 1;
            7'h13: begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 32'(s >>> 20); e.b_sel = 1; e.alu = {f3, i[30]}; writes = 1; end
            7'h33: begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.alu = {f3, i[30]}; writes = 1; end
            7'h0f, 7'h73: ;
            default: e.ill = 1;
        endcase
        e.we = writes && (e.rd != 0);
        return e;
    endfunction

    function automatic logic hits(input logic [4:0] r, input exp_t d);
        return (r != 0) && (d.rs1 == r || d.rs2 == r);
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 11))
            0: i[6:0] = 7'h37;  1: i[6:0] = 7'h17;  2: i[6:0] = 7'h6f;  3: i[6:0] = 7'h67;
            4: i[6:0] = 7'h63;  5: i[6:0] = 7'h03;  6: i[6:0] = 7'h23;  7: i[6:0] = 7'h13;
            8: i[6:0] = 7'h33;  9: i[6:0] = 7'h0f;  10: i[6:0] = 7'h73; default: i[6:0] = 7'h7f;
        endcase
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    logic        m_valid, m_ldp;
    logic [4:0]  m_ldrd;
    exp_t        m_e;
    logic [31:0] m_inst, m_pc, m_iss, m_stl;
    logic [31:0] next_pc = 32'h100;

    task automatic model_reset();
        m_valid = 0; m_ldp = 0; m_ldrd = 0; m_e = '0; m_e.mem = 4'hf;
        m_inst = 0; m_pc = 0; m_iss = 0; m_stl = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle(output logic fin);
        exp_t di;
        logic hz, rdy, fout, cond;
        #1;
        di = ref_decode(bus.in_inst);
        hz = bus.in_valid && ((m_valid && m_e.wb == 2'b01 && hits(m_e.rd, di)) || (m_ldp && hits(m_ldrd, di)));
        rdy = !rst && !bus.flush && !hz && (!m_valid || bus.out_ready);
        check("in_ready", bus.in_ready, rdy);
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            check("out_pc", bus.out_pc, m_pc);
            check("bundle", {bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm, bus.out_alu_mode,
                             bus.out_mem_mode, bus.out_a_sel, bus.out_b_sel, bus.out_wb_sel,
                             bus.out_reg_we, bus.out_branch, bus.out_jump, bus.out_illegal}, m_e);
            case (m_inst[14:12])
                3'd0: cond = bus.br_eq;   3'd1: cond = !bus.br_eq;
                3'd4: cond = bus.br_lt;   3'd5: cond = !bus.br_lt;
                3'd6: cond = bus.br_ltu;  3'd7: cond = !bus.br_ltu;
                default: cond = 0;
            endcase
            check("br_taken", bus.br_taken, (m_e.br && cond) || m_e.jmp);
        end
`ifdef DECODE_PERF_CNT_EN
        check("perf_issued", perf_issued, m_iss);
        check("perf_stall", perf_stall, m_stl);
`endif
        fin  = bus.in_valid && rdy;
        fout = m_valid && bus.out_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (fout) m_iss++;
            if (bus.in_valid && !rdy && !bus.flush) m_stl++;
            m_ldrd = m_e.rd;
            m_ldp  = !bus.flush && fout && m_e.wb == 2'b01;
            if (bus.flush) m_valid = 0;
            else if (fin) begin m_valid = 1; m_e = di; m_inst = bus.in_inst; m_pc = bus.in_pc; end
            else if (fout) m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] inst);
        logic fin;
        fin = 0;
        bus.in_valid = 1; bus.in_inst = inst; bus.in_pc = next_pc;
        for (int k = 0; k < 12 && !fin; k++) cycle(fin);
        check("accepted", fin, 1'b1);
        bus.in_valid = 0;
        next_pc += 4;
    endtask

    initial begin
        logic fin, f_have;
        logic [31:0] bne_pc;
        rst = 1; bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0; bus.flush = 0;
        bus.out_ready = 1; bus.br_eq = 0; bus.br_lt = 0; bus.br_ltu = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        bus.in_valid = 1; #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_mem_mode", bus.out_mem_mode, 4'hf);
        check("rst_imm", bus.out_imm, 32'h0);
        check("rst_rd", bus.out_rd, 5'd0);
        check("rst_reg_we", bus.out_reg_we, 1'b0);
        check("rst_br_taken", bus.br_taken, 1'b0);
        rst = 0; bus.in_valid = 0;

        present(32'h00500093);
        check("addi_valid", bus.out_valid, 1'b1);
        check("addi_rd", bus.out_rd, 5'd1);
        check("addi_imm", bus.out_imm, 32'd5);
        check("addi_b_sel", bus.out_b_sel, 1'b1);
        check("addi_reg_we", bus.out_reg_we, 1'b1);
        check("addi_wb", bus.out_wb_sel, 2'b00);

        present(32'h0000A103);
        present(32'h001101B3);
        check("ldu_add_rd", bus.out_rd, 5'd3);

        bne_pc = next_pc;
        present(32'h00209463);
        bus.out_ready = 0; bus.br_eq = 0; #1;
        check("bne_taken", bus.br_taken, 1'b1);
        check("bne_imm", bus.out_imm, 32'd8);
        bus.br_eq = 1; #1;
        check("bne_not_taken", bus.br_taken, 1'b0);

        bus.in_valid = 1; bus.in_inst = 32'h00A00293; bus.in_pc = next_pc;
        repeat (3) cycle(fin);
        check("stall_pc", bus.out_pc, bne_pc);
        bus.out_ready = 1;
        present(32'h00A00293);

        bus.in_valid = 1; bus.in_inst = 32'h00100113; bus.in_pc = next_pc; bus.flush = 1;
        cycle(fin);
        bus.flush = 0;
        check("flush_out_valid", bus.out_valid, 1'b0);
        present(32'h00100113);

        present(32'h0000007F);
        bus.br_eq = 0; bus.br_lt = 1; bus.br_ltu = 1; #1;
        check("ill_flag", bus.out_illegal, 1'b1);
        check("ill_reg_we", bus.out_reg_we, 1'b0);
        check("ill_mem_mode", bus.out_mem_mode, 4'hf);
        check("ill_br_taken", bus.br_taken, 1'b0);

        bus.in_valid = 1; bus.in_inst = 32'h00500093; bus.in_pc = next_pc; rst = 1;
        cycle(fin);
        rst = 0; bus.in_valid = 0;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_mem_mode", bus.out_mem_mode, 4'hf);
        check("midrst_imm", bus.out_imm, 32'h0);

        f_have = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!f_have && $urandom_range(0, 3) != 0) begin
                f_have = 1; bus.in_inst = gen_inst(); bus.in_pc = next_pc; next_pc += 4;
            end
            bus.in_valid  = f_have;
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.flush     = $urandom_range(0, 19) == 0;
            bus.br_eq     = 1'($urandom); bus.br_lt = 1'($urandom); bus.br_ltu = 1'($urandom);
            rst           = $urandom_range(0, 299) == 0;
            cycle(fin);
            if (fin) f_have = 0;
        end
        rst = 0; bus.flush = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
